// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and its synchronizer.
package freq_meter_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } fm_state_t;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
  localparam int          GATE_W         = 27;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a history flop; emits a one-cycle pulse
// on each rising edge of an asynchronous input.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronizer chain, free-running regardless of what consumes the pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of sig_in over a fixed window of
// clk cycles and latches the (saturating) count when the window closes.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int unsigned GATE_MS = 1000,
  parameter int          CNT_W   = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] freq_count,
  output logic             overflow
);

  localparam longint unsigned GATE_CYCLES = (64'(CLK_HZ) / 64'd1000) * 64'(GATE_MS);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  fm_state_t         state;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat;
  logic              rise;
  logic [CNT_W-1:0]  edge_next;
  logic              sat_next;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Edge count including this cycle's pulse; sticks at all-ones once full
  always_comb begin
    edge_next = edge_cnt;
    sat_next  = sat;
    if (edge_cnt == CNT_MAX) begin
      sat_next = sat | rise;
    end else begin
      edge_next = edge_cnt + CNT_W'(rise);
    end
  end

  // Measurement FSM, gate/edge counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      freq_count <= '0;
      overflow   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= MEASURE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        MEASURE: begin
          gate_cnt <= gate_cnt + GATE_W'(1'b1);
          edge_cnt <= edge_next;
          sat      <= sat_next;
          if (gate_cnt == GATE_LAST) begin
            freq_count <= edge_next;
            overflow   <= sat_next;
            valid      <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter with a sample-history reference model.
module tb_freq_meter;

  localparam int GC   = 100;
  localparam int CW   = 5;
  localparam int MAXC = 31;
  localparam int NSMP = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          valid;
  logic [CW-1:0] freq_count;
  logic          overflow;

  always #5 clk = ~clk;

  freq_meter #(.CLK_HZ(10_000), .GATE_MS(10), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .start      (start),
    .busy       (busy),
    .valid      (valid),
    .freq_count (freq_count),
    .overflow   (overflow)
  );

  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    int due;
    int cnt;
    bit ovf;
  } exp_t;

  exp_t q[$];
  bit   smp[NSMP];
  bit   exp_busy[NSMP];
  bit   m_meas = 1'b0;
  int   m_t = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Reference: a window opened at edge T closes at T+GC and counts every
  // sampled 0->1 transition whose synchronized pulse lands inside it.
  task automatic step(input bit s, input bit st, input bit r);
    int e;
    int c;
    @(negedge clk);
    sig_in = s;
    start  = st;
    rst    = r;
    e = edge_no;
    smp[e] = r ? 1'b0 : s;
    if (r) begin
      m_meas = 1'b0;
    end else if (m_meas && e == m_t + GC) begin
      c = 0;
      for (int n = m_t - 1; n <= m_t + GC - 2; n++)
        if (smp[n] && !(n > 0 && smp[n-1])) c++;
      q.push_back('{e, (c > MAXC) ? MAXC : c, c > MAXC});
      m_meas = 1'b0;
    end else if (!m_meas && st) begin
      m_meas = 1'b1;
      m_t = e;
    end
    exp_busy[e] = m_meas;
    @(posedge clk);
  endtask

  // p=0: random bits; otherwise a wave of period p, high for h samples
  task automatic drive(input int n, input int p, input int h,
                       input int st1, input int st2, input int rs);
    bit s;
    for (int k = 0; k < n; k++) begin
      s = (p == 0) ? 1'($urandom % 2) : ((k % p) < h);
      step(s, (k == st1) || (k == st2), k == rs);
    end
  endtask

  // Monitor: checks busy every cycle and pops the scoreboard on each valid
  initial begin
    int e;
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      e = edge_no - 1;
      chk("busy", int'(busy), int'(exp_busy[e]));
      if (valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          x = q.pop_front();
          chk("valid_edge", e, x.due);
          chk("freq_count", int'(freq_count), x.cnt);
          chk("overflow", int'(overflow), int'(x.ovf));
        end
      end else if (q.size() != 0 && q[0].due <= e) begin
        x = q.pop_front();
        chk("missing_valid", 0, 1);
      end
    end
  end

  initial begin
    int p;
    int h;
    int s0;
    int n;
    drive(3, 1, 0, -1, -1, 0);
    drive(1, 1, 0, -1, -1, -1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_freq_count", int'(freq_count), 0);
    chk("rst_overflow", int'(overflow), 0);

    drive(105, 10, 5, 0, -1, -1);      // 10-clk square wave
    drive(5, 1, 1, -1, -1, -1);
    drive(105, 1, 1, 0, -1, -1);       // held high throughout
    drive(105, 2, 1, 0, -1, -1);       // toggling every clk saturates
    drive(105, 1, 0, 0, -1, -1);       // quiet window clears overflow
    drive(110, 10, 5, 0, 40, -1);      // start mid-window ignored
    drive(51, 7, 3, 0, -1, 50);        // reset mid-window aborts
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_freq_count", int'(freq_count), 0);
    drive(105, 10, 5, 0, -1, -1);
    drive(210, 8, 4, 0, 101, -1);      // back-to-back windows

    for (int i = 0; i < 10; i++) begin
      p  = $urandom_range(0, 20);
      if (p == 1) p = 2;
      h  = (p == 0) ? 0 : $urandom_range(1, p - 1);
      s0 = $urandom_range(0, 3);
      n  = s0 + 101 + $urandom_range(0, 10);
      drive(n, p, h, s0, s0 + $urandom_range(1, 99), -1);
    end

    drive(10, 1, 0, -1, -1, -1);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated edge counter that measures the frequency of a slow external or divided-down signal against the 100 MHz system clock. It is the counterpart of the clock divider: the divider generates a slow clock from `clk`, and this block recovers the rate of such a signal by counting its rising edges over a fixed gate window. It is used for tone/ring detection on each answering-machine channel and for self-checking divider outputs. One instance handles one channel.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: frequency of `clk` in Hz.
- `GATE_MS`, 1000: gate window length in ms. Derived `GATE_CYCLES = CLK_HZ/1000*GATE_MS` must be ≥ 2 and < 2^27.
- `CNT_W`, 27: width of the edge counter and of `freq_count`.

Ports:
- `clk` in 1: system clock. One clock; all logic is on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `sig_in` in 1: signal under measurement. Asynchronous to `clk`.
- `start` in 1: single-cycle request to begin a measurement.
- `busy` out 1: high while a gate window is open.
- `valid` out 1: one-cycle pulse when a result has been latched.
- `freq_count` out CNT_W: rising edges counted in the last completed window. Equals Hz when GATE_MS = 1000.
- `overflow` out 1: the last completed window saturated the edge counter.

## Operation
- Synchronizer: two flops `s1` and `s2`, then a history flop `s3`. `edge = s2 & ~s3`. The synchronizer runs continuously in every state.
- FSM states: `IDLE` and `MEASURE`.
  - `IDLE`: `start`=1 moves to `MEASURE` and clears the gate and edge counters.
  - `MEASURE`: the gate counter increments each cycle. The edge counter increments on each `edge` and saturates at 2^CNT_W−1. When gate count reaches `GATE_CYCLES−1`:
    - latch `freq_count` = edge count including that cycle's `edge`;
    - latch `overflow` = saturated flag;
    - pulse `valid`;
    - return to `IDLE`.
- `start` while in `MEASURE` is ignored. It is not queued.
- An `edge` in the cycle `start` is accepted is not counted.
- `freq_count` and `overflow` hold their values until the next latch or reset.
- Maximum countable rate is CLK_HZ/2. Faster inputs alias. This is not detected.
- Reset, at any time including mid-window: go to `IDLE` and abort the window with no `valid`. All outputs and `s1`/`s2`/`s3` reset to 0.
  - If `sig_in` is high after reset, one rising edge is seen, but it is counted only if a window is open.

## Timing
- Reset values: `busy`=0, `valid`=0, `freq_count`=0, `overflow`=0.
- With `start` sampled high at edge T:
  - `busy`=1 for cycles T+1 … T+GATE_CYCLES, exactly GATE_CYCLES cycles.
  - `valid`=1 and new `freq_count` appear at T+GATE_CYCLES+1.
  - `busy`=0 in that same cycle, and a new `start` is accepted in that cycle.
- `sig_in` to `edge` latency is 2–3 clk. Edges arriving in the last 2 gate cycles may fall into the next window. This is accepted as ±1 count of error.

## Structure
- `freq_meter_pkg`:
  - state enum `fm_state_t` {IDLE, MEASURE};
  - `CLK_HZ_DEFAULT` = 100_000_000;
  - gate counter width constant of 27.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rising-edge pulse, with `clk`/`rst`. It is reused by the keypad and ring-detect paths.
- Top level holds the FSM, the gate counter, the saturating edge counter, and the result registers.

## Test plan
All scenarios use CLK_HZ=10_000, GATE_MS=10, giving GATE_CYCLES=100, unless stated.
- `sig_in` square wave with a 10-clk period, `start` pulse → `busy` for 100 cycles, then `valid` with `freq_count`=10 (±1), `overflow`=0.
- `sig_in` held high before `start`, for the whole window → `freq_count`=0.
- `sig_in` toggling every clk, CNT_W=5 → `freq_count`=31, `overflow`=1. Next window with `sig_in`=0 → `freq_count`=0, `overflow`=0.
- `start` pulsed again at cycle 40 of a window → no restart, `valid` still at T+101, exactly one `valid`.
- `rst` asserted at cycle 50 of a window → `busy`=0 and `freq_count`=0 next cycle, no `valid`. A fresh `start` then measures correctly.
- `start` in the same cycle `valid` is high → back-to-back windows, second `valid` exactly 101 cycles later.
